alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one instance of the 16-bit alu between two requesters (e.g. fetch/address unit and execute unit).
//  Each requester presents operands and an opcode over a valid/ready handshake.
//  A round-robin FSM grants one request at a time, registers operands, drives the alu, and returns the result.
//  Results go back over a per-requester valid/ready response channel.
// PARAMETERS
//  DATA_WIDTH     16  operand/result width; passed to alu
//  SEL_OPERATION  3   opcode width; passed to alu
// PORTS
//  clk_i          in   1              single clock; all state on rising edge
//  rst_n_i        in   1              synchronous, active-low reset
//  req0_valid_i   in   1              requester 0 has an operation
//  req0_ready_o   out  1              requester 0 operation accepted this cycle
//  req0_a_i       in   DATA_WIDTH     operand A
//  req0_b_i       in   DATA_WIDTH     operand B (shift amount for sll/srl)
//  req0_op_i      in   SEL_OPERATION  opcode: sum,sub,not,and,or,xor,sll,srl = 0..7
//  rsp0_valid_o   out  1              result for requester 0 available
//  rsp0_ready_i   in   1              requester 0 takes result
//  rsp0_data_o    out  DATA_WIDTH     result
//  req1_*/rsp1_*  same set as requester 0, for requester 1
//  busy_o         out  1              FSM not in IDLE
//  grant_o        out  1              index of the current/last granted requester
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): state=IDLE, last_grant=1 (req0 wins first tie), all *_ready_o=0,
//   rsp*_valid_o=0, rsp*_data_o=0, busy_o=0, grant_o=1. Reset mid-operation discards the op; no response is issued.
//  IDLE: grant = only valid requester; if both valid, grant = ~last_grant.
//   reqN_ready_o is combinational = (state==IDLE) & reqN_valid_i & (grant==N); at most one ready is high.
//   On handshake: latch a, b, op, grant; go to EXEC.
//  EXEC: one cycle; alu output from latched operands registered into result; go to RESP.
//  RESP: rspG_valid_o=1 and rspG_data_o stable until rspG_ready_i=1.
//   On that edge: valid drops, last_grant=G, go to IDLE. The other rsp channel stays 0.
//  Latency: request handshake at edge T -> rsp valid from T+2.
//   Minimum spacing between accepts is 3 cycles (IDLE->EXEC->RESP->IDLE).
//  Requester rule: valid, a, b and op held stable until ready; a withdrawn request is simply not granted.
//  Arithmetic: modulo 2^DATA_WIDTH; no carry/overflow.
//   not ignores B. sll/srl use full B; B>=DATA_WIDTH yields 0.
//  The rsp data register is not cleared on dequeue; it holds the last result.
// CONFIGURATION
//  ALU_ARB_FLAGS_EN defined: adds rsp0_zero_o, rsp0_neg_o, rsp1_zero_o, rsp1_neg_o.
//   zero = (result==0); neg = result[DATA_WIDTH-1].
//   Both are registered with the result and valid with rspN_valid_o. Reset value 0.
//  Undefined: these ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
//  Package alu_pkg holds the opcode localparams (_sum.._srl), the FSM state encoding (IDLE/EXEC/RESP),
//   and default widths.
//  Sub-module: one instance of the existing alu (dataa_i/datab_i/sel_i/data_o), fed from the latched
//   operand registers. Arbitration and FSM stay in this module.
// TESTING
//  1 Reset then req0 valid a=0x0005 b=0x0003 op=sum -> ready0 at T; rsp0_valid at T+2, data=0x0008.
//  2 Both valid same cycle after reset: req0 sub 0x0003-0x0005, req1 xor 0xFF00^0x0FF0
//    -> req0 first, data=0xFFFE; then req1, data=0xF0F0; then req0 again if still valid.
//  3 rsp0_ready_i held 0 for 5 cycles -> rsp0_valid/data stable, req1 not granted;
//    release -> IDLE next, req1 granted.
//  4 Shifts: sll 0x0001 by 15 -> 0x8000; srl 0x8000 by 16 -> 0x0000; not 0x00FF -> 0xFF00.
//  5 rst_n_i=0 during EXEC and during RESP -> next cycle all outputs at reset values, no rsp pulse;
//    pending req re-arbitrated with req0 priority.
//  6 ALU_ARB_FLAGS_EN: sub 0x0004-0x0004 -> zero=1 neg=0; sub 0x0000-0x0001 -> data=0xFFFF zero=0 neg=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: default widths,
// opcode encodings, FSM state encoding and the round-robin pick function.
package alu_pkg;

  localparam int DATA_WIDTH_DEF    = 16;
  localparam int SEL_OPERATION_DEF = 3;

  localparam logic [2:0] OP_SUM = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end else if (v1) begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU (width parameterised). Arithmetic wraps modulo
// 2^DATA_WIDTH; shifts by DATA_WIDTH or more produce zero; NOT ignores B.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int SEL_OPERATION = SEL_OPERATION_DEF
) (
  input  logic [DATA_WIDTH-1:0]    dataa_i,
  input  logic [DATA_WIDTH-1:0]    datab_i,
  input  logic [SEL_OPERATION-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]    data_o
);

  localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  logic shift_oob;
  assign shift_oob = (datab_i >= SHIFT_LIMIT);

  // Opcode decode; the full B operand is the shift amount.
  always_comb begin
    data_o = '0;
    case (sel_i)
      SEL_OPERATION'(OP_SUM): data_o = dataa_i + datab_i;
      SEL_OPERATION'(OP_SUB): data_o = dataa_i - datab_i;
      SEL_OPERATION'(OP_NOT): data_o = ~dataa_i;
      SEL_OPERATION'(OP_AND): data_o = dataa_i & datab_i;
      SEL_OPERATION'(OP_OR):  data_o = dataa_i | datab_i;
      SEL_OPERATION'(OP_XOR): data_o = dataa_i ^ datab_i;
      SEL_OPERATION'(OP_SLL): data_o = shift_oob ? '0 : (dataa_i << datab_i);
      SEL_OPERATION'(OP_SRL): data_o = shift_oob ? '0 : (dataa_i >> datab_i);
      default:                data_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. A round-robin IDLE/EXEC/RESP FSM
// accepts one request, latches its operands, registers the ALU result and
// holds it on that requester's response channel until it is taken.
// Optional feature macro: ALU_ARB_FLAGS_EN adds registered zero/neg flags
// per response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int SEL_OPERATION = SEL_OPERATION_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req0_valid_i,
  output logic                     req0_ready_o,
  input  logic [DATA_WIDTH-1:0]    req0_a_i,
  input  logic [DATA_WIDTH-1:0]    req0_b_i,
  input  logic [SEL_OPERATION-1:0] req0_op_i,
  output logic                     rsp0_valid_o,
  input  logic                     rsp0_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp0_data_o,
  input  logic                     req1_valid_i,
  output logic                     req1_ready_o,
  input  logic [DATA_WIDTH-1:0]    req1_a_i,
  input  logic [DATA_WIDTH-1:0]    req1_b_i,
  input  logic [SEL_OPERATION-1:0] req1_op_i,
  output logic                     rsp1_valid_o,
  input  logic                     rsp1_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp1_data_o,
`ifdef ALU_ARB_FLAGS_EN
  output logic                     rsp0_zero_o,
  output logic                     rsp0_neg_o,
  output logic                     rsp1_zero_o,
  output logic                     rsp1_neg_o,
`endif
  output logic                     busy_o,
  output logic                     grant_o
);

  state_e                          state_q, state_d;
  logic                            last_grant_q, last_grant_d;
  logic                            grant_q, grant_d;
  logic [DATA_WIDTH-1:0]           a_q, a_d;
  logic [DATA_WIDTH-1:0]           b_q, b_d;
  logic [SEL_OPERATION-1:0]        op_q, op_d;
  logic [1:0]                      rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
`ifdef ALU_ARB_FLAGS_EN
  logic [1:0]                      zero_q, zero_d;
  logic [1:0]                      neg_q, neg_d;
`endif

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_ready;
  logic                  arb_sel;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_out;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign arb_sel   = arb_pick(req0_valid_i, req1_valid_i, last_grant_q);

  // Ready is held low while reset is asserted so no request is lost to a reset edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = rst_n_i && (state_q == ST_IDLE) && req_valid[gi]
                             && (arb_sel == 1'(gi));
    end
  endgenerate

  assign accept = |req_ready;

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SEL_OPERATION(SEL_OPERATION)
  ) u_alu (
    .dataa_i(a_q),
    .datab_i(b_q),
    .sel_i  (op_q),
    .data_o (alu_out)
  );

  // Next-state logic for the arbitration FSM and its datapath registers.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
`ifdef ALU_ARB_FLAGS_EN
    zero_d       = zero_q;
    neg_d        = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = arb_sel ? req1_a_i  : req0_a_i;
          b_d     = arb_sel ? req1_b_i  : req0_b_i;
          op_d    = arb_sel ? req1_op_i : req0_op_i;
          grant_d = arb_sel;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d[grant_q]  = alu_out;
        rsp_valid_d[grant_q] = 1'b1;
`ifdef ALU_ARB_FLAGS_EN
        zero_d[grant_q]      = (alu_out == '0);
        neg_d[grant_q]       = alu_out[DATA_WIDTH-1];
`endif
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d[grant_q] = 1'b0;
          last_grant_d         = grant_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
`ifdef ALU_ARB_FLAGS_EN
      zero_q       <= '0;
      neg_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
`ifdef ALU_ARB_FLAGS_EN
      zero_q       <= zero_d;
      neg_q        <= neg_d;
`endif
    end
  end

  assign req0_ready_o = req_ready[0];
  assign req1_ready_o = req_ready[1];
  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_data_o  = rsp_data_q[0];
  assign rsp1_data_o  = rsp_data_q[1];
`ifdef ALU_ARB_FLAGS_EN
  assign rsp0_zero_o  = zero_q[0];
  assign rsp0_neg_o   = neg_q[0];
  assign rsp1_zero_o  = zero_q[1];
  assign rsp1_neg_o   = neg_q[1];
`endif
  assign busy_o       = (state_q != ST_IDLE);
  assign grant_o      = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations plus
// hand-written sequences for arbitration, backpressure and reset corners.
module tb_alu_arbiter;

  localparam logic [2:0] OSUM = 3'd0, OSUB = 3'd1, ONOT = 3'd2, OAND = 3'd3,
                         OOR  = 3'd4, OXOR = 3'd5, OSLL = 3'd6, OSRL = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [15:0] req0_a, req0_b, rsp0_data;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [15:0] req1_a, req1_b, rsp1_data;
  logic [2:0]  req1_op;
  logic        busy, grant;
`ifdef ALU_ARB_FLAGS_EN
  logic        rsp0_zero, rsp0_neg, rsp1_zero, rsp1_neg;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req0_op_i   (req0_op),
    .rsp0_valid_o(rsp0_valid),
    .rsp0_ready_i(rsp0_ready),
    .rsp0_data_o (rsp0_data),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .req1_op_i   (req1_op),
    .rsp1_valid_o(rsp1_valid),
    .rsp1_ready_i(rsp1_ready),
    .rsp1_data_o (rsp1_data),
`ifdef ALU_ARB_FLAGS_EN
    .rsp0_zero_o (rsp0_zero),
    .rsp0_neg_o  (rsp0_neg),
    .rsp1_zero_o (rsp1_zero),
    .rsp1_neg_o  (rsp1_neg),
`endif
    .busy_o      (busy),
    .grant_o     (grant)
  );

  typedef struct {
    logic        idx;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic idx, input logic v, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b);
    if (!idx) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic rdy(input logic idx);
    return idx ? req1_ready : req0_ready;
  endfunction

  function automatic logic rvld(input logic idx);
    return idx ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [15:0] rdat(input logic idx);
    return idx ? rsp1_data : rsp0_data;
  endfunction

  task automatic set_rsp_ready(input logic idx, input logic v);
    if (!idx) rsp0_ready = v;
    else      rsp1_ready = v;
  endtask

  // One full transaction with latency checks: accept at edge T, EXEC in the
  // following cycle, response valid two cycles after the accept.
  task automatic run_op(input string nm, input logic idx, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    @(negedge clk);
    drive_req(idx, 1'b1, op, a, b);
    #1;
    check({nm, " ready"}, 32'(rdy(idx)), 32'd1);
    check({nm, " other ready"}, 32'(rdy(~idx)), 32'd0);
    @(negedge clk);
    drive_req(idx, 1'b0, op, a, b);
    check({nm, " exec busy"}, 32'(busy), 32'd1);
    check({nm, " exec rsp valid"}, 32'(rvld(idx)), 32'd0);
    check({nm, " grant"}, 32'(grant), 32'(idx));
    @(negedge clk);
    check({nm, " rsp valid"}, 32'(rvld(idx)), 32'd1);
    check({nm, " other rsp valid"}, 32'(rvld(~idx)), 32'd0);
    check({nm, " data"}, 32'(rdat(idx)), 32'(exp));
    set_rsp_ready(idx, 1'b1);
    @(negedge clk);
    set_rsp_ready(idx, 1'b0);
    check({nm, " dequeued valid"}, 32'(rvld(idx)), 32'd0);
    check({nm, " idle"}, 32'(busy), 32'd0);
    check({nm, " data held"}, 32'(rdat(idx)), 32'(exp));
    $display("[TB] %s: req%0d op=%0d a=0x%04h b=0x%04h -> 0x%04h (expect 0x%04h)",
             nm, idx, op, a, b, rdat(idx), exp);
  endtask

`ifdef ALU_ARB_FLAGS_EN
  // Flags checked while the response is valid.
  task automatic run_flags(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input logic ez, input logic en);
    @(negedge clk);
    drive_req(1'b0, 1'b1, OSUB, a, b);
    @(negedge clk);
    drive_req(1'b0, 1'b0, OSUB, a, b);
    @(negedge clk);
    check({nm, " valid"}, 32'(rsp0_valid), 32'd1);
    check({nm, " data"}, 32'(rsp0_data), 32'(exp));
    check({nm, " zero"}, 32'(rsp0_zero), 32'(ez));
    check({nm, " neg"}, 32'(rsp0_neg), 32'(en));
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    $display("[TB] %s: data=0x%04h zero=%0b neg=%0b", nm, rsp0_data, rsp0_zero, rsp0_neg);
  endtask
`endif

  initial begin
    vecs[0]  = '{1'b0, OSUM, 16'h0005, 16'h0003, 16'h0008};
    vecs[1]  = '{1'b1, OSUB, 16'h0003, 16'h0005, 16'hFFFE};
    vecs[2]  = '{1'b0, ONOT, 16'h00FF, 16'h1234, 16'hFF00};
    vecs[3]  = '{1'b1, OAND, 16'hF0F0, 16'h3C3C, 16'h3030};
    vecs[4]  = '{1'b0, OOR,  16'hF000, 16'h000F, 16'hF00F};
    vecs[5]  = '{1'b1, OXOR, 16'hFF00, 16'h0FF0, 16'hF0F0};
    vecs[6]  = '{1'b0, OSLL, 16'h0001, 16'd15,   16'h8000};
    vecs[7]  = '{1'b1, OSRL, 16'h8000, 16'd16,   16'h0000};
    vecs[8]  = '{1'b0, OSLL, 16'h0001, 16'd16,   16'h0000};
    vecs[9]  = '{1'b1, OSRL, 16'h8000, 16'd15,   16'h0001};
    vecs[10] = '{1'b0, OSUM, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[11] = '{1'b1, OSLL, 16'h00F0, 16'hFFFF, 16'h0000};

    rst_n = 1'b0;
    drive_req(1'b0, 1'b1, OSUM, 16'h0, 16'h0);
    drive_req(1'b1, 1'b1, OSUM, 16'h0, 16'h0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset state, with both requests asserted to confirm ready stays low.
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset grant", 32'(grant), 32'd1);
    check("reset ready0", 32'(req0_ready), 32'd0);
    check("reset ready1", 32'(req1_ready), 32'd0);
    check("reset rsp0 valid", 32'(rsp0_valid), 32'd0);
    check("reset rsp1 valid", 32'(rsp1_valid), 32'd0);
    check("reset rsp0 data", 32'(rsp0_data), 32'd0);
    check("reset rsp1 data", 32'(rsp1_data), 32'd0);
    drive_req(1'b0, 1'b0, OSUM, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OSUM, 16'h0, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Tie: last grant was req1, so req0 wins; req1 served next; then req0 wins again.
    @(negedge clk);
    drive_req(1'b0, 1'b1, OSUB, 16'h0003, 16'h0005);
    drive_req(1'b1, 1'b1, OXOR, 16'hFF00, 16'h0FF0);
    #1;
    check("tie ready0", 32'(req0_ready), 32'd1);
    check("tie ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("tie grant0", 32'(grant), 32'd0);
    @(negedge clk);
    check("tie rsp0 data", 32'(rsp0_data), 32'h0000FFFE);
    check("tie rsp0 valid", 32'(rsp0_valid), 32'd1);
    check("tie rsp1 quiet", 32'(rsp1_valid), 32'd0);
    check("tie ready1 blocked", 32'(req1_ready), 32'd0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("tie ready1 after", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("tie rsp1 data", 32'(rsp1_data), 32'h0000F0F0);
    check("tie rsp0 quiet", 32'(rsp0_valid), 32'd0);
    rsp1_ready = 1'b1;
    drive_req(1'b0, 1'b1, OSUM, 16'h0001, 16'h0001);
    drive_req(1'b1, 1'b1, OSUM, 16'h0002, 16'h0002);
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    check("tie again ready0", 32'(req0_ready), 32'd1);
    check("tie again ready1", 32'(req1_ready), 32'd0);
    drive_req(1'b0, 1'b0, OSUM, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OSUM, 16'h0, 16'h0);
    $display("[TB] tie sequence: req0 0x%04h, req1 0x%04h", rsp0_data, rsp1_data);

    // Backpressure: response held 5 cycles, req1 waits, then gets granted.
    @(negedge clk);
    drive_req(1'b0, 1'b1, OSUM, 16'h1234, 16'h1111);
    @(negedge clk);
    drive_req(1'b0, 1'b0, OSUM, 16'h0, 16'h0);
    drive_req(1'b1, 1'b1, OSUM, 16'h0001, 16'h0001);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d valid", c), 32'(rsp0_valid), 32'd1);
      check($sformatf("hold%0d data", c), 32'(rsp0_data), 32'h00002345);
      check($sformatf("hold%0d ready1", c), 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    check("hold release valid", 32'(rsp0_valid), 32'd0);
    #1;
    check("hold release ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("hold req1 data", 32'(rsp1_data), 32'h00000002);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    $display("[TB] backpressure sequence: req0 0x%04h held, req1 0x%04h", rsp0_data, rsp1_data);

    // Leave last_grant=0 so that a post-reset tie only goes to req0 because of reset.
    run_op("pre-reset", 1'b0, OAND, 16'hFFFF, 16'h00AA, 16'h00AA);

    // Reset during EXEC.
    @(negedge clk);
    drive_req(1'b0, 1'b1, OSUM, 16'hAAAA, 16'h0001);
    @(negedge clk);
    check("rstexec busy before", 32'(busy), 32'd1);
    req1_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstexec busy", 32'(busy), 32'd0);
    check("rstexec grant", 32'(grant), 32'd1);
    check("rstexec rsp0 valid", 32'(rsp0_valid), 32'd0);
    check("rstexec rsp0 data", 32'(rsp0_data), 32'd0);
    check("rstexec ready0", 32'(req0_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstexec rearb ready0", 32'(req0_ready), 32'd1);
    check("rstexec rearb ready1", 32'(req1_ready), 32'd0);
    drive_req(1'b0, 1'b0, OSUM, 16'h0, 16'h0);
    drive_req(1'b1, 1'b0, OSUM, 16'h0, 16'h0);
    @(negedge clk);
    check("rstexec no rsp", 32'(rsp0_valid), 32'd0);
    $display("[TB] reset during EXEC: busy=%0b rsp0_valid=%0b", busy, rsp0_valid);

    // Reset during RESP.
    @(negedge clk);
    drive_req(1'b0, 1'b1, OSUM, 16'h0100, 16'h0001);
    @(negedge clk);
    drive_req(1'b0, 1'b0, OSUM, 16'h0, 16'h0);
    @(negedge clk);
    check("rstresp valid before", 32'(rsp0_valid), 32'd1);
    check("rstresp data before", 32'(rsp0_data), 32'h00000101);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstresp valid", 32'(rsp0_valid), 32'd0);
    check("rstresp data", 32'(rsp0_data), 32'd0);
    check("rstresp busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rstresp no pulse", 32'(rsp0_valid), 32'd0);
    $display("[TB] reset during RESP: rsp0_valid=%0b data=0x%04h", rsp0_valid, rsp0_data);

`ifdef ALU_ARB_FLAGS_EN
    run_flags("flags zero", 16'h0004, 16'h0004, 16'h0000, 1'b1, 1'b0);
    run_flags("flags neg", 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
